// File: rtl/countdown_pkg.sv
// countdown shared types and constants.
// Three-digit BCD game timer.
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic [3:0] bcd_sat(
    input logic [3:0] d
  );
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/countdown_bcd_digit_dec.sv
// One BCD digit of a ripple decrementer.
// Borrows out when a zero digit is decremented.
module bcd_digit_dec
  import countdown_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       borrow_in,
  output logic [3:0] digit_next,
  output logic       borrow_out
);

  logic is_zero;

  assign is_zero = (digit == 4'd0);

  // decrement with wrap 0 -> 9
  always_comb begin
    digit_next = digit;
    borrow_out = 1'b0;
    if (borrow_in) begin
      digit_next = is_zero ? BCD_MAX
                           : digit - 4'd1;
      borrow_out = is_zero;
    end
  end

endmodule

// File: rtl/countdown.sv
// Three-digit BCD countdown with start/pause
// and a sticky lose flag at 000.
module countdown
  import countdown_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] init_time,
  input  logic        SwitchOp,
  input  logic        SecTimer,
  output logic [3:0]  value_three,
  output logic [3:0]  value_two,
  output logic [3:0]  value_one,
  output logic        loose_control
);

  state_t     state, state_n;
  logic       sw_q, sec_q;
  logic       start_ev, tick_ev;
  logic [3:0] d3_n, d2_n, d1_n;
  logic       lose_n;
  logic [3:0] ld3, ld2, ld1;
  logic [3:0] dec3, dec2, dec1;
  logic       b1, b2, b3;
  logic       at_one, ld_zero;

  assign start_ev = SwitchOp & ~sw_q;
  assign tick_ev  = SecTimer & ~sec_q;

  assign ld3 = bcd_sat(init_time[11:8]);
  assign ld2 = bcd_sat(init_time[7:4]);
  assign ld1 = bcd_sat(init_time[3:0]);

  assign ld_zero = (ld3 == 4'd0) &&
                   (ld2 == 4'd0) &&
                   (ld1 == 4'd0);

  assign at_one = (value_three == 4'd0) &&
                  (value_two   == 4'd0) &&
                  (value_one   == 4'd1);

  bcd_digit_dec u_ones (
    .digit      (value_one),
    .borrow_in  (1'b1),
    .digit_next (dec1),
    .borrow_out (b1)
  );

  bcd_digit_dec u_tens (
    .digit      (value_two),
    .borrow_in  (b1),
    .digit_next (dec2),
    .borrow_out (b2)
  );

  bcd_digit_dec u_hund (
    .digit      (value_three),
    .borrow_in  (b2),
    .digit_next (dec3),
    .borrow_out (b3)
  );

  // previous-cycle samples for edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_q  <= 1'b0;
      sec_q <= 1'b0;
    end else begin
      sw_q  <= SwitchOp;
      sec_q <= SecTimer;
    end
  end

  // next state, next digits and next flag
  always_comb begin
    state_n = state;
    d3_n    = value_three;
    d2_n    = value_two;
    d1_n    = value_one;
    lose_n  = loose_control;
    unique case (state)
      IDLE: begin
        d3_n = ld3;
        d2_n = ld2;
        d1_n = ld1;
        if (start_ev) begin
          if (ld_zero) begin
            state_n = EXPIRED;
            lose_n  = 1'b1;
          end else begin
            state_n = RUNNING;
          end
        end
      end
      RUNNING: begin
        if (start_ev) begin
          state_n = PAUSED;
        end else if (tick_ev && !b3) begin
          d3_n = dec3;
          d2_n = dec2;
          d1_n = dec1;
          if (at_one) begin
            state_n = EXPIRED;
            lose_n  = 1'b1;
          end
        end
      end
      PAUSED: begin
        if (start_ev) state_n = RUNNING;
      end
      EXPIRED: begin
        d3_n   = 4'd0;
        d2_n   = 4'd0;
        d1_n   = 4'd0;
        lose_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // state, digit and flag registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      value_three   <= 4'd0;
      value_two     <= 4'd0;
      value_one     <= 4'd0;
      loose_control <= 1'b0;
    end else begin
      state         <= state_n;
      value_three   <= d3_n;
      value_two     <= d2_n;
      value_one     <= d1_n;
      loose_control <= lose_n;
    end
  end

endmodule

// File: tb/tb_countdown.sv
// Directed bench for countdown.
// Expected digits are hand-computed.
module tb_countdown;

  logic        clk;
  logic        reset;
  logic [11:0] init_time;
  logic        SwitchOp;
  logic        SecTimer;
  logic [3:0]  value_three;
  logic [3:0]  value_two;
  logic [3:0]  value_one;
  logic        loose_control;

  int checks;
  int errors;

  countdown dut (
    .clk           (clk),
    .reset         (reset),
    .init_time     (init_time),
    .SwitchOp      (SwitchOp),
    .SecTimer      (SecTimer),
    .value_three   (value_three),
    .value_two     (value_two),
    .value_one     (value_one),
    .loose_control (loose_control)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string      tag,
    input logic [11:0] exp_d,
    input logic        exp_l
  );
    logic [11:0] got;
    got = {value_three, value_two, value_one};
    checks++;
    assert (got === exp_d) else begin
      errors++;
      $error("FAIL %s digits got %h want %h",
             tag, got, exp_d);
    end
    checks++;
    assert (loose_control === exp_l) else begin
      errors++;
      $error("FAIL %s lose got %b want %b",
             tag, loose_control, exp_l);
    end
  endtask

  task automatic tick();
    SecTimer = 1'b1;
    step();
    SecTimer = 1'b0;
    step();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press();
    SwitchOp = 1'b1;
    step();
    SwitchOp = 1'b0;
    step();
  endtask

  task automatic do_reset(input logic [11:0] t);
    reset     = 1'b0;
    init_time = t;
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b0;
    init_time = 12'h190;
    SwitchOp  = 1'b0;
    SecTimer  = 1'b0;

    step();
    step();
    chk("reset", 12'h000, 1'b0);
    reset = 1'b1;
    step();
    chk("load", 12'h190, 1'b0);

    press();
    chk("started", 12'h190, 1'b0);
    tick();
    chk("tick1", 12'h189, 1'b0);
    ticks(9);
    chk("tick10", 12'h180, 1'b0);
    ticks(15);
    chk("tick25", 12'h165, 1'b0);

    SecTimer = 1'b1;
    for (int i = 0; i < 5; i++) step();
    SecTimer = 1'b0;
    step();
    chk("long_tick", 12'h164, 1'b0);

    press();
    ticks(3);
    chk("paused", 12'h164, 1'b0);
    press();
    tick();
    chk("resumed", 12'h163, 1'b0);

    SwitchOp = 1'b1;
    SecTimer = 1'b1;
    step();
    SwitchOp = 1'b0;
    SecTimer = 1'b0;
    step();
    chk("pause_wins", 12'h163, 1'b0);
    ticks(2);
    chk("pause_hold", 12'h163, 1'b0);

    SwitchOp = 1'b1;
    SecTimer = 1'b1;
    step();
    SwitchOp = 1'b0;
    SecTimer = 1'b0;
    step();
    chk("resume_no_tick", 12'h163, 1'b0);
    tick();
    chk("resume_tick", 12'h162, 1'b0);

    ticks(20);
    chk("at_142", 12'h142, 1'b0);
    init_time = 12'h100;
    reset = 1'b0;
    #2;
    chk("async_reset", 12'h000, 1'b0);
    step();
    reset = 1'b1;
    step();
    chk("reload", 12'h100, 1'b0);
    ticks(2);
    chk("idle_no_tick", 12'h100, 1'b0);
    press();
    tick();
    chk("borrow", 12'h099, 1'b0);

    do_reset(12'h001);
    chk("load_001", 12'h001, 1'b0);
    press();
    tick();
    chk("expire", 12'h000, 1'b1);
    ticks(3);
    press();
    chk("expired_hold", 12'h000, 1'b1);

    do_reset(12'h000);
    chk("load_000", 12'h000, 1'b0);
    SwitchOp = 1'b1;
    step();
    SwitchOp = 1'b0;
    chk("zero_start", 12'h000, 1'b1);

    do_reset(12'hFAF);
    chk("sat_load", 12'h999, 1'b0);
    init_time = 12'h250;
    step();
    chk("idle_follow", 12'h250, 1'b0);

    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

endmodule
